// File: rtl/piso_serializer_pkg.sv
// Shared types and defaults for the parallel-in serial-out serializer.
package piso_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/piso_bit_counter.sv
// Down-counter of bits remaining in the current word; saturates at zero.
module piso_bit_counter
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero,
    output logic one
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(WIDTH - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == CW'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready load and bit-rate enable.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             shift_en,
    output logic             sdata,
    output logic             sframe,
    output logic             slast,
    output logic             busy
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] sreg_d;
    logic [WIDTH-1:0] sreg_shift;
    logic             sframe_q;
    logic             sframe_d;
    logic             slast_q;
    logic             slast_d;
    logic             hs;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             cnt_one;

    piso_bit_counter #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .load(cnt_load),
        .dec (cnt_dec),
        .zero(cnt_zero),
        .one (cnt_one)
    );

    // The output end of the register is the bit currently on sdata.
    assign sreg_shift = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg_q[WIDTH-1:1]};

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        sframe_d   = sframe_q;
        slast_d    = slast_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        load_ready = (state_q == IDLE) || (cnt_zero && shift_en);
        hs         = load_valid && load_ready;
        unique case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d  = SHIFT;
                    sreg_d   = din;
                    sframe_d = 1'b1;
                    slast_d  = 1'b0;
                    cnt_load = 1'b1;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (!cnt_zero) begin
                        sreg_d  = sreg_shift;
                        slast_d = cnt_one;
                        cnt_dec = 1'b1;
                    end else if (hs) begin
                        sreg_d   = din;
                        sframe_d = 1'b1;
                        slast_d  = 1'b0;
                        cnt_load = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        sreg_d   = '0;
                        sframe_d = 1'b0;
                        slast_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = IDLE;
                sreg_d   = '0;
                sframe_d = 1'b0;
                slast_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            sframe_q <= 1'b0;
            slast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            sframe_q <= sframe_d;
            slast_q  <= slast_d;
        end
    end

    assign sdata  = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign sframe = sframe_q;
    assign slast  = slast_q;
    assign busy   = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed checks of piso_serializer against a word/position model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid;
    logic [7:0] din;
    logic       shift_en;

    logic rdy_m, sd_m, fr_m, ls_m, bz_m;
    logic rdy_l, sd_l, fr_l, ls_l, bz_l;

    int vectors    = 0;
    int miscompares = 0;
    bit chk_on     = 1'b0;

    bit         m_active = 1'b0;
    int         m_k      = 0;
    logic [7:0] m_word   = '0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_m),
        .din(din), .shift_en(shift_en), .sdata(sd_m), .sframe(fr_m),
        .slast(ls_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(rdy_l),
        .din(din), .shift_en(shift_en), .sdata(sd_l), .sframe(fr_l),
        .slast(ls_l), .busy(bz_l)
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Model: which word is on the wire and how many of its bits went out.
    always @(posedge clk) begin
        bit rdy;
        rdy = !m_active || (m_k == 7 && shift_en);
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (rdy && load_valid) begin
            m_active = 1'b1;
            m_word   = din;
            m_k      = 0;
        end else if (m_active && shift_en) begin
            if (m_k == 7) m_active = 1'b0;
            else m_k = m_k + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic er, el, eb_m, eb_l;
            er   = !m_active || (m_k == 7 && shift_en);
            el   = m_active && (m_k == 7);
            eb_m = m_active ? m_word[7-m_k] : 1'b0;
            eb_l = m_active ? m_word[m_k] : 1'b0;
            chk("ready_m", 32'(rdy_m), 32'(er));
            chk("ready_l", 32'(rdy_l), 32'(er));
            chk("busy_m", 32'(bz_m), 32'(m_active));
            chk("busy_l", 32'(bz_l), 32'(m_active));
            chk("sframe_m", 32'(fr_m), 32'(m_active));
            chk("sframe_l", 32'(fr_l), 32'(m_active));
            chk("slast_m", 32'(ls_m), 32'(el));
            chk("slast_l", 32'(ls_l), 32'(el));
            chk("sdata_m", 32'(sd_m), 32'(eb_m));
            chk("sdata_l", 32'(sd_l), 32'(eb_l));
        end
    end

    initial begin
        logic [31:0] sm, sl, mk;
        int nfr;

        rst = 1'b1;
        load_valid = 1'b0;
        din = '0;
        shift_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(rdy_m), 32'd1);
        chk("rst_sdata", 32'(sd_m), 32'd0);
        chk("rst_sframe", 32'(fr_m), 32'd0);
        chk("rst_slast", 32'(ls_m), 32'd0);
        chk("rst_busy", 32'(bz_m), 32'd0);

        // 0xC1, continuous enable, both bit orders
        cyc();
        load_valid = 1'b1;
        din = 8'hC1;
        shift_en = 1'b1;
        cyc();
        load_valid = 1'b0;
        din = '0;
        sm = '0; sl = '0; mk = '0; nfr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            sm = {sm[30:0], sd_m};
            sl = {sl[30:0], sd_l};
            mk = {mk[30:0], ls_m};
            nfr += int'(fr_m);
            cyc();
        end
        chk("c1_msb_seq", sm, 32'hC1);
        chk("c1_lsb_seq", sl, 32'h83);
        chk("c1_slast", mk, 32'h01);
        chk("c1_frames", 32'(nfr), 32'd8);
        @(negedge clk);
        chk("c1_end_sframe", 32'(fr_m), 32'd0);

        // enable 1 in 3, next word offered throughout
        cyc();
        load_valid = 1'b1;
        din = 8'hC1;
        shift_en = 1'b1;
        cyc();
        din = 8'hFF;
        sm = '0;
        for (int i = 0; i < 24; i++) begin
            shift_en = (i % 3 == 2);
            @(negedge clk);
            sm = {sm[30:0], sd_m};
            cyc();
        end
        chk("slow_seq", sm & 32'hFFFFFF, 32'hFC0007);
        load_valid = 1'b0;
        shift_en = 1'b1;
        repeat (9) cyc();

        // back-to-back 0x0F, 0xF0
        load_valid = 1'b1;
        din = 8'h0F;
        cyc();
        din = 8'hF0;
        sm = '0; mk = '0; nfr = 0;
        for (int i = 0; i < 16; i++) begin
            load_valid = (i < 8);
            @(negedge clk);
            sm = {sm[30:0], sd_m};
            mk = {mk[30:0], ls_m};
            nfr += int'(fr_m);
            cyc();
        end
        chk("b2b_seq", sm, 32'h0FF0);
        chk("b2b_slast", mk, 32'h0101);
        chk("b2b_frames", 32'(nfr), 32'd16);
        load_valid = 1'b0;
        cyc();

        // reset mid-word
        load_valid = 1'b1;
        din = 8'hC1;
        cyc();
        load_valid = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_sframe", 32'(fr_m), 32'd0);
        chk("abort_sdata", 32'(sd_m), 32'd0);
        chk("abort_ready", 32'(rdy_m), 32'd1);
        nfr = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            @(negedge clk);
            nfr += int'(fr_m) + int'(fr_l);
        end
        chk("abort_no_bits", 32'(nfr), 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst        = ($urandom_range(0, 99) == 0);
            load_valid = ($urandom_range(0, 2) != 0);
            din        = 8'($urandom);
            shift_en   = ($urandom_range(0, 3) != 0);
        end
        cyc();
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
